// File: rtl/emif_cal_bus_msg_capture.sv
// Passive cal-bus print monitor: unpacks debug-address writes into a char FIFO.
// Define CAL_MSG_SIM_PRINT_EN for a simulation-only "[EMIF CAL]" line printer.
module emif_cal_bus_msg_capture #(
   parameter logic [19:0] DEBUG_ADDR    = 20'h1_0000,
   parameter int unsigned FIFO_DEPTH    = 64,
   parameter int unsigned MSG_CNT_WIDTH = 16
) (
   input  logic                         cal_bus_clk,
   input  logic                         cal_bus_reset_n,
   input  logic                         cal_bus_avl_write,
   input  logic [19:0]                  cal_bus_avl_address,
   input  logic [31:0]                  cal_bus_avl_write_data,
   output logic                         msg_char_valid,
   output logic [7:0]                   msg_char,
   output logic                         msg_char_eom,
   input  logic                         msg_char_ready,
   output logic [MSG_CNT_WIDTH-1:0]     msg_count,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_UNPACK = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] unpack_q, unpack_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_vld_q, hold_vld_d;
   logic [1:0]  idx_q, idx_d;

   logic        hit;
   logic [7:0]  cur_byte;
   logic        push, push_eom, push_ok;
   logic        word_end, word_drop, char_drop;

   logic [8:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] level_q, level_d;
   logic [MSG_CNT_WIDTH-1:0] cnt_q;
   logic        ovf_q;
   logic        pop, full;

   assign hit      = cal_bus_avl_write && (cal_bus_avl_address == DEBUG_ADDR);
   assign cur_byte = unpack_q[{idx_q, 3'b000} +: 8];
   assign push     = (state_q == S_UNPACK);
   assign push_eom = (cur_byte == 8'h00);
   assign word_end = push && (push_eom || (idx_q == 2'd3));

   always_comb begin
      state_d    = state_q;
      unpack_d   = unpack_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      idx_d      = idx_q;
      word_drop  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               unpack_d = cal_bus_avl_write_data;
               idx_d    = 2'd0;
               state_d  = S_UNPACK;
            end
         end
         default: begin
            word_drop = hit && hold_vld_q;
            if (word_end) begin
               idx_d = 2'd0;
               if (hold_vld_q) begin
                  unpack_d   = hold_q;
                  hold_vld_d = 1'b0;
               end else if (hit) begin
                  // hold is free: the new word streams straight in
                  unpack_d = cal_bus_avl_write_data;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               idx_d = idx_q + 2'd1;
               if (hit && !hold_vld_q) begin
                  hold_d     = cal_bus_avl_write_data;
                  hold_vld_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge cal_bus_clk or negedge cal_bus_reset_n) begin
      if (!cal_bus_reset_n) begin
         state_q    <= S_IDLE;
         unpack_q   <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         unpack_q   <= unpack_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         idx_q      <= idx_d;
      end
   end

   assign msg_char_valid = (level_q != '0);
   assign pop       = msg_char_valid && msg_char_ready;
   assign full      = (level_q == FULL_LVL);
   assign push_ok   = push && (!full || pop);
   assign char_drop = push && full && !pop;

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge cal_bus_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {push_eom, cur_byte};
   end

   always_ff @(posedge cal_bus_clk or negedge cal_bus_reset_n) begin
      if (!cal_bus_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         if (push_ok && push_eom && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
         // a drop in the clearing cycle keeps the flag raised
         if (word_drop || char_drop) ovf_q <= 1'b1;
         else if (overflow_clr)      ovf_q <= 1'b0;
      end
   end

   assign msg_char     = msg_char_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
   assign msg_char_eom = msg_char_valid && mem_q[rd_ptr_q][8];
   assign msg_count    = cnt_q;
   assign fifo_level   = level_q;
   assign overflow     = ovf_q;

`ifdef CAL_MSG_SIM_PRINT_EN
`ifndef SYNTHESIS
   string msg_str_q;

   always @(posedge cal_bus_clk) begin
      if (push_ok) begin
         if (push_eom) begin
            $display("[EMIF CAL] %s", msg_str_q);
            msg_str_q <= "";
         end else begin
            msg_str_q <= $sformatf("%s%c", msg_str_q, cur_byte);
         end
      end
   end
`endif
`endif

endmodule

// File: tb/tb_emif_cal_bus_msg_capture.sv
// Bench for emif_cal_bus_msg_capture: directed plan plus random traffic
// against a word-queue / char-queue reference model.
module tb_emif_cal_bus_msg_capture;

   localparam logic [19:0] DBG = 20'h1_0000;
   localparam int DEPTH = 4;
   localparam int CNTW  = 4;
   localparam int CMAX  = (1 << CNTW) - 1;

   logic              clk;
   logic              rst_n;
   logic              wr;
   logic [19:0]       addr;
   logic [31:0]       wd;
   logic              valid;
   logic [7:0]        mchar;
   logic              eom;
   logic              ready;
   logic [CNTW-1:0]   mcount;
   logic [$clog2(DEPTH):0] level;
   logic              ovf;
   logic              clr;

   int checks = 0;
   int failures = 0;

   // reference model state
   int unsigned wq[$];
   int          widx;
   logic [8:0]  fq[$];
   int          mcnt;
   bit          movf;

   emif_cal_bus_msg_capture #(
      .DEBUG_ADDR(DBG),
      .FIFO_DEPTH(DEPTH),
      .MSG_CNT_WIDTH(CNTW)
   ) dut (
      .cal_bus_clk(clk),
      .cal_bus_reset_n(rst_n),
      .cal_bus_avl_write(wr),
      .cal_bus_avl_address(addr),
      .cal_bus_avl_write_data(wd),
      .msg_char_valid(valid),
      .msg_char(mchar),
      .msg_char_eom(eom),
      .msg_char_ready(ready),
      .msg_count(mcount),
      .fifo_level(level),
      .overflow(ovf),
      .overflow_clr(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      wq.delete();
      fq.delete();
      widx = 0;
      mcnt = 0;
      movf = 0;
   endtask

   // What the monitor does at one clock edge, from the current inputs.
   task automatic model_tick();
      bit hitm, accept, popm, pushm, setev;
      logic [7:0] b;
      logic [8:0] ent;
      hitm   = wr && (addr == DBG);
      accept = hitm && (wq.size() < 2);
      popm   = (fq.size() > 0) && ready;
      pushm  = 0;
      setev  = hitm && !accept;
      ent    = '0;
      if (wq.size() > 0) begin
         b = 8'(wq[0] >> (8 * widx));
         ent = {(b == 8'h00), b};
         pushm = 1;
         if (b == 8'h00 || widx == 3) begin
            void'(wq.pop_front());
            widx = 0;
         end else begin
            widx++;
         end
      end
      if (accept) wq.push_back(wd);
      if (popm) void'(fq.pop_front());
      if (pushm) begin
         if (fq.size() < DEPTH) begin
            fq.push_back(ent);
            if (ent[8] && mcnt < CMAX) mcnt++;
         end else begin
            setev = 1;
         end
      end
      if (setev) movf = 1;
      else if (clr) movf = 0;
   endtask

   task automatic check_all();
      chk("valid", 32'(valid), 32'(fq.size() > 0));
      if (fq.size() > 0) begin
         chk("char", 32'(mchar), 32'(fq[0][7:0]));
         chk("eom", 32'(eom), 32'(fq[0][8]));
      end
      chk("level", 32'(level), 32'(fq.size()));
      chk("msg_count", 32'(mcount), 32'(mcnt));
      chk("overflow", 32'(ovf), 32'(movf));
   endtask

   task automatic cycle();
      model_tick();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wr_word(input logic [19:0] a, input logic [31:0] d);
      wr = 1'b1;
      addr = a;
      wd = d;
      cycle();
      wr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_char"}, 32'(mchar), 0);
      chk({tag, "_eom"}, 32'(eom), 0);
      chk({tag, "_count"}, 32'(mcount), 0);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_ovf"}, 32'(ovf), 0);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(0, 4) == 0) w[k*8 +: 8] = 8'h00;
         else w[k*8 +: 8] = 8'($urandom_range(1, 255));
      end
      return w;
   endfunction

   initial begin
      rst_n = 1'b0;
      wr = 1'b0;
      addr = '0;
      wd = '0;
      ready = 1'b1;
      clr = 1'b0;
      model_clear();
      #1;
      check_reset_vals("rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // "Cal" message, byte 0 visible one edge after capture
      wr_word(DBG, 32'h006C_6143);
      chk("t1_lat_edge", 32'(valid), 0);
      cycle();
      chk("t1_first", 32'(mchar), 32'h43);
      idle(6);
      chk("t1_count", 32'(mcount), 1);

      // "Hello" spans two back-to-back words
      wr_word(DBG, 32'h6C6C_6548);
      wr_word(DBG, 32'h0000_006F);
      idle(9);
      chk("t2_count", 32'(mcount), 2);

      // other address and a read are ignored
      wr_word(20'h1_0004, 32'h4141_4141);
      addr = DBG;
      wd = 32'h4242_4242;
      idle(3);
      chk("t3_level", 32'(level), 0);

      // third back-to-back word overflows the hold register
      wr_word(DBG, 32'h4443_4241);
      wr_word(DBG, 32'h4847_4645);
      wr_word(DBG, 32'h4C4B_4A49);
      chk("t4_ovf", 32'(ovf), 1);
      idle(10);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      chk("t4_clr", 32'(ovf), 0);
      wr_word(DBG, 32'h0000_0000);
      idle(4);
      chk("t4_count", 32'(mcount), 3);

      // consumer stalled: FIFO fills, 'E' and terminator dropped
      ready = 1'b0;
      wr_word(DBG, 32'h4443_4241);
      wr_word(DBG, 32'h0000_0045);
      idle(8);
      chk("t5_level", 32'(level), DEPTH);
      chk("t5_ovf", 32'(ovf), 1);
      chk("t5_count", 32'(mcount), 3);
      ready = 1'b1;
      clr = 1'b1;
      idle(6);
      clr = 1'b0;

      // reset in the middle of unpacking
      wr_word(DBG, 32'h4443_4241);
      cycle();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_reset_vals("t6");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr_word(DBG, 32'h0000_0000);
      idle(3);
      chk("t6_count", 32'(mcount), 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 2) == 0);
         addr = ($urandom_range(0, 3) == 0) ? 20'h1_0004 : DBG;
         wd = rand_word();
         ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         cycle();
      end
      wr = 1'b0;
      ready = 1'b1;
      clr = 1'b0;
      idle(12);

      // counter saturation
      for (int i = 0; i < CMAX + 3; i++) begin
         wr_word(DBG, 32'h0000_0000);
         idle(1);
      end
      idle(4);
      chk("sat_count", 32'(mcount), CMAX);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
